quick_spi_slave: RTL and testbench

//  SPI responder (slave) for the quick_spi master, in one system clock domain.

---
 rtl/quick_spi_slave.sv | 210 +++++++++++++++++++++
 tb/tb_quick_spi_slave.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/quick_spi_slave.sv
// Oversampled SPI responder: shifts out a latched multi-byte word and assembles MOSI bytes.
// Optional idle-SCLK abort enabled by defining QUICK_SPI_SLAVE_TIMEOUT_EN.
module quick_spi_slave #(
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          BITS_ORDER  = 1'b1,
  parameter bit          BYTES_ORDER = 1'b0,
  parameter int unsigned TX_BYTES    = 2
`ifdef QUICK_SPI_SLAVE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [8*TX_BYTES-1:0] tx_data,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  end_of_transaction,
  output logic                  tx_overrun,
  output logic                  timeout
);

  localparam int unsigned TX_W  = 8 * TX_BYTES;
  localparam int unsigned CNT_W = $clog2(TX_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_d;

  logic sclk_meta, sclk_sync, sclk_prev;
  logic ss_meta, ss_sync;
  logic mosi_meta, mosi_sync;
  logic [1:0] flush_cnt;
  logic       armed;

  logic leading, trailing, sample_edge, shift_edge;
  logic start, timeout_d;

  logic [TX_W-1:0]  tx_seq;
  logic [TX_W-1:0]  tx_sr;
  logic [7:0]       rx_sr;
  logic [7:0]       rx_next;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] sample_cnt;

  // Two-flop synchronizers, reset to the bus idle levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_meta <= CPOL;
      sclk_sync <= CPOL;
      sclk_prev <= CPOL;
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      ss_meta   <= ss_n;
      ss_sync   <= ss_meta;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  // armed only once ss_n is genuinely seen high after the pipeline has flushed its reset value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt <= 2'd0;
      armed     <= 1'b0;
    end else begin
      if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
      armed <= (flush_cnt == 2'd3) && ss_sync;
    end
  end

  assign leading     = (sclk_prev == CPOL) && (sclk_sync != CPOL);
  assign trailing    = (sclk_prev != CPOL) && (sclk_sync == CPOL);
  assign sample_edge = CPHA ? trailing : leading;
  assign shift_edge  = CPHA ? leading  : trailing;

  // Reorder tx_data into transmission order, first bit at the MSB
  for (genvar k = 0; k < TX_W; k++) begin : g_map
    localparam int unsigned KU    = k;
    localparam int unsigned BYTE_I = BYTES_ORDER ? (TX_BYTES - 1 - KU / 8) : (KU / 8);
    localparam int unsigned BIT_I  = BITS_ORDER ? (7 - KU % 8) : (KU % 8);
    assign tx_seq[TX_W-1-k] = tx_data[BYTE_I*8+BIT_I];
  end

  always_comb begin
    rx_next = BITS_ORDER ? {rx_sr[6:0], mosi_sync} : {mosi_sync, rx_sr[7:1]};
  end

`ifdef QUICK_SPI_SLAVE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  // Idle-SCLK watchdog, restarted by every SCLK edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (state != ACTIVE || leading || trailing) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !leading && !trailing;
`else
  logic to_hit;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state and control decode
  always_comb begin
    state_d   = state;
    start     = 1'b0;
    timeout_d = 1'b0;
    case (state)
      IDLE: begin
        if (enable && armed && !ss_sync) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_sync || !enable) begin
          state_d = DONE;
        end else if (to_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso               <= 1'b0;
      miso_oe            <= 1'b0;
      rx_data            <= 8'h00;
      rx_valid           <= 1'b0;
      busy               <= 1'b0;
      end_of_transaction <= 1'b0;
      tx_overrun         <= 1'b0;
      timeout            <= 1'b0;
      tx_sr              <= '0;
      rx_sr              <= 8'h00;
      bit_cnt            <= 3'd0;
      sample_cnt         <= '0;
    end else begin
      busy               <= (state_d == ACTIVE);
      miso_oe            <= (state_d == ACTIVE);
      end_of_transaction <= (state_d == DONE);
      timeout            <= timeout_d;
      rx_valid           <= 1'b0;
      if (start) begin
        tx_sr      <= CPHA ? tx_seq : (tx_seq << 1);
        miso       <= CPHA ? 1'b0 : tx_seq[TX_W-1];
        rx_sr      <= 8'h00;
        bit_cnt    <= 3'd0;
        sample_cnt <= '0;
        tx_overrun <= 1'b0;
      end else if (state == ACTIVE) begin
        if (shift_edge) begin
          miso  <= tx_sr[TX_W-1];
          tx_sr <= tx_sr << 1;
        end
        // a sample coinciding with deselect still completes its byte
        if (sample_edge) begin
          rx_sr   <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
          end
          if (sample_cnt == CNT_W'(TX_W)) tx_overrun <= 1'b1;
          else                            sample_cnt <= sample_cnt + CNT_W'(1);
        end
        if (state_d != ACTIVE) miso <= 1'b0;
      end else begin
        miso <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quick_spi_slave.sv
// Randomized bench for quick_spi_slave: mode 0 (LSB first, big endian) and mode 3
// (MSB first, little endian) instances driven by one master against a reference model.
module tb_quick_spi_slave;

  localparam int HALF = 5;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        ss_n;
  logic        mosi;
  logic        sclk_a, sclk_b;
  logic [15:0] tx_a, tx_b;

  logic       miso_a, miso_oe_a, rx_valid_a, busy_a, eot_a, ovr_a, to_a;
  logic       miso_b, miso_oe_b, rx_valid_b, busy_b, eot_b, ovr_b, to_b;
  logic [7:0] rx_data_a, rx_data_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int eot_cnt_a = 0;
  int eot_cnt_b = 0;

  quick_spi_slave #(.CPOL(1'b0), .CPHA(1'b0), .BITS_ORDER(1'b0), .BYTES_ORDER(1'b1), .TX_BYTES(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tx_data(tx_a),
    .sclk(sclk_a), .ss_n(ss_n), .mosi(mosi),
    .miso(miso_a), .miso_oe(miso_oe_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .busy(busy_a), .end_of_transaction(eot_a), .tx_overrun(ovr_a), .timeout(to_a)
  );

  quick_spi_slave #(.CPOL(1'b1), .CPHA(1'b1), .BITS_ORDER(1'b1), .BYTES_ORDER(1'b0), .TX_BYTES(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tx_data(tx_b),
    .sclk(sclk_b), .ss_n(ss_n), .mosi(mosi),
    .miso(miso_b), .miso_oe(miso_oe_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .busy(busy_b), .end_of_transaction(eot_b), .tx_overrun(ovr_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid_a) q_a.push_back(rx_data_a);
    if (rx_valid_b) q_b.push_back(rx_data_b);
    if (eot_a) eot_cnt_a++;
    if (eot_b) eot_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit k of the transfer as seen on MISO
  function automatic logic exp_miso(input logic [15:0] d, input int k, input bit msb_first,
                                    input bit big_endian);
    int b, j, byte_i, bit_i;
    if (k >= 16) return 1'b0;
    b      = k / 8;
    j      = k % 8;
    byte_i = big_endian ? 1 - b : b;
    bit_i  = msb_first ? 7 - j : j;
    return d[byte_i*8+bit_i];
  endfunction

  // Byte n assembled from MOSI bits in transfer order
  function automatic logic [7:0] exp_rx(input logic [31:0] m, input int n, input bit msb_first);
    int v = 0;
    for (int j = 0; j < 8; j++)
      if (m[8*n+j]) v += msb_first ? (1 << (7 - j)) : (1 << j);
    return 8'(v);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_outs"}, {miso_a, miso_oe_a, rx_valid_a, busy_a, eot_a, ovr_a, to_a}, 7'd0);
    check({tag, "_b_outs"}, {miso_b, miso_oe_b, rx_valid_b, busy_b, eot_b, ovr_b, to_b}, 7'd0);
    check({tag, "_a_rx"}, rx_data_a, 8'h00);
    check({tag, "_b_rx"}, rx_data_b, 8'h00);
  endtask

  // Clock nbits SCLK periods (no checking), used for aborted transfers
  task automatic clock_bits(input int nbits);
    for (int k = 0; k < nbits; k++) begin
      sclk_b = 1'b0; mosi = $urandom_range(0, 1);
      wait_clk(HALF);
      sclk_a = 1'b1; sclk_b = 1'b1;
      wait_clk(HALF);
      sclk_a = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb, input int nbits,
                         input logic [31:0] m);
    int  base_a, base_b, eb_a, eb_b, nbytes;
    bit  en;
    en     = enable;
    tx_a   = ta;
    tx_b   = tb;
    base_a = q_a.size();
    base_b = q_b.size();
    eb_a   = eot_cnt_a;
    eb_b   = eot_cnt_b;
    wait_clk(2);
    ss_n = 1'b0;
    wait_clk(2 * HALF);
    for (int k = 0; k < nbits; k++) begin
      sclk_b = 1'b0;
      mosi   = m[k];
      wait_clk(HALF);
      if (k == 0) begin
        check("busy_a", busy_a, en);
        check("busy_b", busy_b, en);
        check("oe_a", miso_oe_a, en);
        check("oe_b", miso_oe_b, en);
      end
      check($sformatf("miso_a_bit%0d", k), miso_a, en ? exp_miso(ta, k, 1'b0, 1'b1) : 1'b0);
      check($sformatf("miso_b_bit%0d", k), miso_b, en ? exp_miso(tb, k, 1'b1, 1'b0) : 1'b0);
      sclk_a = 1'b1; sclk_b = 1'b1;
      wait_clk(HALF);
      sclk_a = 1'b0;
    end
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(10);
    check("idle_a", {busy_a, miso_oe_a, miso_a}, 3'b000);
    check("idle_b", {busy_b, miso_oe_b, miso_b}, 3'b000);
    check("eot_a", eot_cnt_a - eb_a, en ? 1 : 0);
    check("eot_b", eot_cnt_b - eb_b, en ? 1 : 0);
    check("ovr_a", ovr_a, en && nbits > 16);
    check("ovr_b", ovr_b, en && nbits > 16);
    nbytes = en ? nbits / 8 : 0;
    check("nrx_a", q_a.size() - base_a, nbytes);
    check("nrx_b", q_b.size() - base_b, nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (base_a + i < q_a.size()) check($sformatf("rx_a%0d", i), q_a[base_a+i], exp_rx(m, i, 1'b0));
      if (base_b + i < q_b.size()) check($sformatf("rx_b%0d", i), q_b[base_b+i], exp_rx(m, i, 1'b1));
    end
  endtask

  initial begin
    int qa0, qb0;
    reset_n = 1'b0;
    enable  = 1'b1;
    ss_n    = 1'b1;
    mosi    = 1'b0;
    sclk_a  = 1'b0;
    sclk_b  = 1'b1;
    tx_a    = 16'h0000;
    tx_b    = 16'h0000;
    wait_clk(3);
    check_reset_vals("rst");
    reset_n = 1'b1;
    wait_clk(10);

    // Directed transfers from the datasheet examples
    run_txn(16'hCC82, 16'hA55A, 16, 32'h0000_3C95);
    if (q_a.size() >= 2) begin
      check("dir_rx_a0", q_a[q_a.size()-2], 8'h95);
      check("dir_rx_a1", q_a[q_a.size()-1], 8'h3C);
    end
    run_txn(16'hCC82, 16'hA55A, 8, 32'h0000_000F);
    if (q_b.size() >= 1) check("dir_rx_b", q_b[q_b.size()-1], 8'hF0);

    // Overrun: 20 SCLKs against a 2-byte word
    run_txn(16'h1234, 16'hBEEF, 20, $urandom);

    // Randomized transfers, including partial trailing bytes
    for (int t = 0; t < 10; t++)
      run_txn(16'($urandom), 16'($urandom), $urandom_range(1, 24), $urandom);

    // Disabled responder ignores the bus
    enable = 1'b0;
    run_txn(16'($urandom), 16'($urandom), 12, $urandom);
    enable = 1'b1;
    wait_clk(5);

    // Reset in the middle of a transfer with ss_n still low
    qa0 = q_a.size();
    qb0 = q_b.size();
    tx_a = 16'($urandom);
    tx_b = 16'($urandom);
    ss_n = 1'b0;
    wait_clk(2 * HALF);
    clock_bits(5);
    reset_n = 1'b0;
    wait_clk(2);
    check_reset_vals("midrst");
    reset_n = 1'b1;
    wait_clk(30);
    check("rearm_busy_a", busy_a, 1'b0);
    check("rearm_busy_b", busy_b, 1'b0);
    check("midrst_nrx_a", q_a.size() - qa0, 0);
    check("midrst_nrx_b", q_b.size() - qb0, 0);
    ss_n = 1'b1;
    wait_clk(10);
    run_txn(16'($urandom), 16'($urandom), 16, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
